// File: rtl/tick_stretcher_pkg.sv
// Shared definitions for the tick stretcher: state encodings, default
// parameters and a helper for the gap counter load value.
package tick_stretcher_pkg;

   localparam int DEF_W   = 8;
   localparam int DEF_GAP = 2;
   localparam int GAP_CNT_W = 8;

   // The unused encoding 2'b11 is treated as illegal and recovers to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HOLD = 2'b01,
      ST_GAP  = 2'b10
   } state_t;

   function automatic logic [GAP_CNT_W-1:0] gapLoadValue(input int gap);
      return GAP_CNT_W'(gap - 1);
   endfunction

endpackage

// File: rtl/tick_stretcher_if.sv
// Bundles the trigger inputs and the stretched-pulse outputs of the
// tick stretcher so producer and consumer share one port.
interface tick_stretcher_if #(
   parameter int W = 8
);
   logic         tick;
   logic [W-1:0] len;
   logic         retrig_en;
   logic         level;
   logic         busy;
   logic         done;

   modport master (
      output tick,
      output len,
      output retrig_en,
      input  level,
      input  busy,
      input  done
   );

   modport slave (
      input  tick,
      input  len,
      input  retrig_en,
      output level,
      output busy,
      output done
   );
endinterface

// File: rtl/tick_stretcher_down_counter.sv
// Loadable down counter with a zero flag; load wins over decrement and the
// count saturates at zero instead of wrapping.
module down_counter_load #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] loadVal_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = loadVal_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tick_stretcher.sv
// Stretches single-cycle ticks into level pulses of programmable length,
// with a guaranteed low gap between pulses and optional retriggering.
module tick_stretcher
   import tick_stretcher_pkg::*;
#(
   parameter int W   = DEF_W,
   parameter int GAP = DEF_GAP
) (
   input  logic clk,
   input  logic reset_n,
   tick_stretcher_if.slave bus
);

   state_t state_q;
   state_t state_d;
   logic   pending_q;
   logic   pending_d;
   logic   level_q;
   logic   busy_q;
   logic   done_q;

   logic         holdLoad;
   logic         holdDec;
   logic         holdZero;
   logic [W-1:0] holdLoadVal;
   logic         gapLoad;
   logic         gapDec;
   logic         gapZero;
   logic [GAP_CNT_W-1:0] gapLoadVal;

   // A zero length behaves like a length of one.
   assign holdLoadVal = (bus.len == '0) ? '0 : (bus.len - W'(1));
   assign gapLoadVal  = gapLoadValue(GAP);

   down_counter_load #(.W(W)) uHoldCnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (holdLoad),
      .loadVal_i (holdLoadVal),
      .dec_i     (holdDec),
      .zero_o    (holdZero)
   );

   down_counter_load #(.W(GAP_CNT_W)) uGapCnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (gapLoad),
      .loadVal_i (gapLoadVal),
      .dec_i     (gapDec),
      .zero_o    (gapZero)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      holdLoad  = 1'b0;
      holdDec   = 1'b0;
      gapLoad   = 1'b0;
      gapDec    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.tick) begin
               holdLoad = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Retrigger beats expiry so the level never dips low.
            if (bus.tick && bus.retrig_en) begin
               holdLoad = 1'b1;
            end else begin
               if (bus.tick) begin
                  pending_d = 1'b1;
               end
               if (holdZero) begin
                  gapLoad = 1'b1;
                  state_d = ST_GAP;
               end else begin
                  holdDec = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gapZero) begin
               if (pending_q || bus.tick) begin
                  holdLoad  = 1'b1;
                  pending_d = 1'b0;
                  state_d   = ST_HOLD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gapDec = 1'b1;
               if (bus.tick) begin
                  pending_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         level_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         level_q   <= (state_d == ST_HOLD);
         busy_q    <= (state_d == ST_HOLD) || (state_d == ST_GAP);
         done_q    <= (state_q == ST_HOLD) && (state_d == ST_GAP);
      end
   end

   assign bus.level = level_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_tick_stretcher.sv
// Directed-vector bench for tick_stretcher: per-cycle bit masks give the
// expected level/busy/done for each scenario.
module tb_tick_stretcher;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   tick_stretcher_if #(.W(8)) bus ();

   tick_stretcher #(.W(8), .GAP(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Cycle c starts just after rising edge c; tick for cycle c is driven
   // there and outputs for cycle c are checked there as well.
   task automatic applyStimulus(input string name, input logic [7:0] lenVal, input logic retrig,
                                input logic [15:0] tickMask, input logic [15:0] expLevel,
                                input logic [15:0] expBusy, input logic [15:0] expDone,
                                input int nCycles);
      bus.len       = lenVal;
      bus.retrig_en = retrig;
      for (int c = 0; c < nCycles; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s level c%0d", name, c), {31'b0, bus.level}, {31'b0, expLevel[c]});
         checkOutput($sformatf("%s busy c%0d", name, c), {31'b0, bus.busy}, {31'b0, expBusy[c]});
         checkOutput($sformatf("%s done c%0d", name, c), {31'b0, bus.done}, {31'b0, expDone[c]});
         bus.tick = tickMask[c];
      end
      bus.tick = 1'b0;
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      bus.tick      = 1'b0;
      bus.len       = 8'd0;
      bus.retrig_en = 1'b0;
      reset_n       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset level", {31'b0, bus.level}, 32'd0);
      checkOutput("reset busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("reset done", {31'b0, bus.done}, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);

      // Reset mid-pulse: tick at cycle 0, reset asserted inside cycle 2.
      applyStimulus("rstPre", 8'd4, 1'b0, 16'h0001, 16'h0006, 16'h0006, 16'h0000, 3);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rstMid level", {31'b0, bus.level}, 32'd0);
      checkOutput("rstMid busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("rstMid done", {31'b0, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      applyStimulus("rstPost", 8'd4, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8);

      applyStimulus("single", 8'd5, 1'b0, 16'h0001, 16'h003E, 16'h00FE, 16'h0040, 10);
      applyStimulus("zeroLen", 8'd0, 1'b0, 16'h0001, 16'h0002, 16'h000E, 16'h0004, 6);
      applyStimulus("pending", 8'd3, 1'b0, 16'h0005, 16'h01CE, 16'h07FE, 16'h0210, 13);
      applyStimulus("retrig", 8'd3, 1'b1, 16'h0009, 16'h007E, 16'h01FE, 16'h0080, 11);
      applyStimulus("lastGap", 8'd2, 1'b0, 16'h0011, 16'h0066, 16'h01FE, 16'h0088, 12);
      applyStimulus("burst", 8'd2, 1'b0, 16'h0007, 16'h0066, 16'h01FE, 16'h0088, 12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tick_stretcher.md
Name: tick_stretcher

Overview:
- Inverse of a level-to-tick edge detector: converts single-cycle ticks into a clean level pulse of programmable length.
- Sits between tick sources (edge detectors, timers) and level-sensitive consumers (LEDs, enables, slow peripherals).
- A guaranteed low gap separates successive pulses, so a downstream positive-edge detector sees every pulse.
- Optional retrigger extends the active pulse instead of queuing a new one.

Parameters:
- W, 8, width of the length input and hold counter.
- GAP, 2, number of low cycles forced after each pulse; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle trigger; a multi-cycle high counts as one trigger per cycle.
- len  input  W  pulse length in cycles; sampled only on load; 0 is treated as 1.
- retrig_en  input  1  1 = a tick during HOLD reloads the counter; 0 = the tick is queued as pending.
- level  output  1  stretched pulse; registered.
- busy  output  1  high in HOLD or GAP; registered.
- done  output  1  one-cycle pulse in the first GAP cycle after each pulse ends; registered.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, level=0, busy=0, done=0, pending=0, counters=0.
  - Reset during HOLD or GAP aborts immediately; a pending trigger is discarded.
- States are IDLE, HOLD and GAP, Moore-encoded. level=1 only in HOLD; busy=1 in HOLD and GAP.
- Load action: hcnt <= (len==0 ? 0 : len-1); state <= HOLD. Effective length L = max(len,1).
- IDLE:
  - tick=1 performs a load. level rises on the clock edge after the tick cycle (latency 1).
- HOLD:
  - level stays high for exactly L consecutive cycles.
  - hcnt decrements each cycle; when hcnt==0, go to GAP and load gcnt <= GAP-1.
  - tick with retrig_en=1 reloads hcnt from the current len and stays in HOLD. This has priority over expiry, including on the hcnt==0 cycle, so level has no glitch low.
  - tick with retrig_en=0 sets pending=1. Multiple ticks collapse into one pending trigger.
- GAP:
  - level=0 for exactly GAP cycles; done=1 in the first GAP cycle only.
  - gcnt decrements each cycle; a tick in any GAP cycle sets pending.
  - At gcnt==0: if pending, or tick is high this cycle, perform a load, clear pending and go to HOLD. Otherwise go to IDLE.
- Minimum low time between pulses equals GAP, regardless of tick timing.
- Back-to-back ticks with retrig_en=0 produce exactly two pulses: the current one plus one pending.
- Width rules:
  - Counters are W bits, unsigned; there is no wrap because a load always precedes a decrement.
  - gcnt is 8 bits.
- Changes to len while in HOLD have no effect unless a retrigger occurs.

Decomposition:
- Shared package:
  - 2-bit state encodings IDLE=2'b00, HOLD=2'b01, GAP=2'b10.
  - Default W and GAP constants.
  - Unreachable state 2'b11 returns to IDLE.
- One natural sub-module, down_counter_load: a W-bit loadable down counter with a zero flag, instantiated twice (hold counter and gap counter).
- FSM and output registers stay in the top module.

Test Plan:
- Reset mid-pulse: len=4, tick at cycle 0, reset_n=0 at cycle 2 -> level, busy and done drop to 0 asynchronously; no pulse after release without a new tick.
- Single trigger: len=5, GAP=2, tick at cycle 0 -> level=1 in cycles 1-5; done=1 in cycle 6; busy=1 in cycles 1-7; back to IDLE at cycle 8.
- Zero length: len=0, tick at cycle 0 -> level=1 only in cycle 1; done in cycle 2.
- Pending, no retrigger: len=3, retrig_en=0, ticks at cycles 0 and 2 -> level high in cycles 1-3; low in cycles 4-5; high in cycles 6-8; done in cycles 4 and 9.
- Retrigger: len=3, retrig_en=1, ticks at cycles 0 and 3 -> level high continuously in cycles 1-6; a single done in cycle 7.
- Tick on last GAP cycle: len=2, tick at cycles 0 and 4 (GAP=2) -> second pulse level high in cycles 5-6; gap low for exactly 2 cycles; no pending is left over.
